// File: rtl/temporizador_regressivo.sv
// Per-player countdown clock: prescaled decrement, Fischer bonus on a move,
// expiry flag. Ports: clock/zera_n, commands carrega/inicia/pausa/jogada,
// bonus; outputs Q (remaining), pulso (decrement strobe), fim, estado.
module temporizador_regressivo #(
  parameter int M       = 6000,
  parameter int N       = 13,
  parameter int INICIAL = 3000,
  parameter int DIV     = 50000,
  parameter int B       = 4
) (
  input  logic         clock,
  input  logic         zera_n,
  input  logic         carrega,
  input  logic         inicia,
  input  logic         pausa,
  input  logic         jogada,
  input  logic [B-1:0] bonus,
  output logic [N-1:0] Q,
  output logic         pulso,
  output logic         fim,
  output logic [1:0]   estado
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef logic [PW-1:0] presc_t;
  typedef logic [N-1:0]  q_t;
  typedef logic [N:0]    sum_t;

  localparam presc_t P_MAX  = presc_t'(DIV - 1);
  localparam sum_t   CAP    = sum_t'(M - 1);
  localparam q_t     Q_INIT = q_t'(INICIAL);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_EXP   = 2'b11
  } state_t;

  state_t st_q, st_d;
  q_t     q_q, q_d;
  presc_t presc_q, presc_d;
  logic   pulso_q, pulso_d;

  sum_t   sum;
  q_t     q_bonus;
  logic   tick;
  logic   can_add;
  logic   can_go;

  // Saturating add of the move bonus, done one bit wider so no wrap.
  assign sum     = {1'b0, q_q} + sum_t'(bonus);
  assign q_bonus = (sum > CAP) ? CAP[N-1:0] : sum[N-1:0];

  assign tick    = (st_q == S_RUN) && (presc_q == P_MAX);
  assign can_add = (st_q == S_RUN) || (st_q == S_PAUSE);
  assign can_go  = (st_q == S_IDLE) || (st_q == S_PAUSE);

  always_comb begin
    st_d    = st_q;
    q_d     = q_q;
    presc_d = presc_q;
    pulso_d = 1'b0;
    if (carrega) begin
      st_d    = S_IDLE;
      q_d     = Q_INIT;
      presc_d = '0;
    end else if (jogada && can_add) begin
      // A move in the tick cycle wins: the tick is simply dropped.
      st_d    = S_PAUSE;
      q_d     = q_bonus;
      presc_d = '0;
    end else if (pausa && (st_q == S_RUN)) begin
      st_d = S_PAUSE;
    end else if (inicia && can_go) begin
      st_d = (q_q != '0) ? S_RUN : S_EXP;
    end else if (st_q == S_RUN) begin
      if (tick) begin
        presc_d = '0;
        q_d     = q_q - q_t'(1);
        pulso_d = 1'b1;
        if (q_q == q_t'(1)) begin
          st_d = S_EXP;
        end
      end else begin
        presc_d = presc_q + presc_t'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge zera_n) begin
    if (!zera_n) begin
      st_q    <= S_IDLE;
      q_q     <= Q_INIT;
      presc_q <= '0;
      pulso_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      q_q     <= q_d;
      presc_q <= presc_d;
      pulso_q <= pulso_d;
    end
  end

  assign Q      = q_q;
  assign pulso  = pulso_q;
  assign fim    = (st_q == S_EXP);
  assign estado = st_q;

endmodule

// File: tb/tb_temporizador_regressivo.sv
// Directed bench for temporizador_regressivo with M=16, N=5, INICIAL=10,
// DIV=4, B=3: vector table plus hand sequences for multi-cycle cases.
module tb_temporizador_regressivo;

  localparam logic [1:0] ID = 2'b00;
  localparam logic [1:0] RU = 2'b01;
  localparam logic [1:0] PA = 2'b10;
  localparam logic [1:0] EX = 2'b11;

  logic       clock = 1'b0;
  logic       zera_n;
  logic       carrega, inicia, pausa, jogada;
  logic [2:0] bonus;
  logic [4:0] Q;
  logic       pulso, fim;
  logic [1:0] estado;

  int checks = 0;
  int errors = 0;

  temporizador_regressivo #(
    .M(16), .N(5), .INICIAL(10), .DIV(4), .B(3)
  ) dut (
    .clock  (clock),
    .zera_n (zera_n),
    .carrega(carrega),
    .inicia (inicia),
    .pausa  (pausa),
    .jogada (jogada),
    .bonus  (bonus),
    .Q      (Q),
    .pulso  (pulso),
    .fim    (fim),
    .estado (estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       c, i, p, j;
    logic [2:0] b;
    logic [4:0] q;
    logic       pl;
    logic [1:0] st;
  } vec_t;

  vec_t tbl[28];

  task automatic chk(input string nm, input logic [4:0] eq,
                     input logic ep, input logic [1:0] es);
    logic ef;
    ef = (es == EX);
    checks++;
    if (Q !== eq || pulso !== ep || estado !== es || fim !== ef) begin
      errors++;
      $display("FAIL %s: got Q=%0d pulso=%b estado=%b fim=%b, want Q=%0d pulso=%b estado=%b fim=%b",
               nm, Q, pulso, estado, fim, eq, ep, es, ef);
    end
  endtask

  task automatic cyc(input logic c, input logic i, input logic p,
                     input logic j, input logic [2:0] b);
    carrega = c; inicia = i; pausa = p; jogada = j; bonus = b;
    @(posedge clock);
    #1;
    carrega = 0; inicia = 0; pausa = 0; jogada = 0; bonus = 0;
  endtask

  // Running with prescaler at 0: count Q from qs down to qe.
  task automatic run_to(input int qs, input int qe, input string nm);
    for (int q = qs; q > qe; q--) begin
      for (int k = 0; k < 3; k++) begin
        cyc(0, 0, 0, 0, 0);
        chk(nm, 5'(q), 1'b0, RU);
      end
      cyc(0, 0, 0, 0, 0);
      chk(nm, 5'(q - 1), 1'b1, (q == 1) ? EX : RU);
    end
  endtask

  initial begin
    // c i p j b   q pl st
    tbl[0]  = '{0,0,1,0,3'd0, 5'd10,0,ID};
    tbl[1]  = '{0,0,0,1,3'd3, 5'd10,0,ID};
    tbl[2]  = '{0,1,0,0,3'd0, 5'd10,0,RU};
    tbl[3]  = '{0,0,0,0,3'd0, 5'd10,0,RU};
    tbl[4]  = '{0,0,0,0,3'd0, 5'd10,0,RU};
    tbl[5]  = '{0,0,0,0,3'd0, 5'd10,0,RU};
    tbl[6]  = '{0,0,0,0,3'd0, 5'd9, 1,RU};
    tbl[7]  = '{0,0,0,0,3'd0, 5'd9, 0,RU};
    tbl[8]  = '{0,0,0,0,3'd0, 5'd9, 0,RU};
    tbl[9]  = '{0,0,0,0,3'd0, 5'd9, 0,RU};
    tbl[10] = '{0,0,0,0,3'd0, 5'd8, 1,RU};
    tbl[11] = '{0,0,1,0,3'd0, 5'd8, 0,PA};
    tbl[12] = '{0,0,1,0,3'd0, 5'd8, 0,PA};
    tbl[13] = '{0,0,0,1,3'd7, 5'd15,0,PA};
    tbl[14] = '{0,0,0,1,3'd1, 5'd15,0,PA};
    tbl[15] = '{0,1,0,0,3'd0, 5'd15,0,RU};
    tbl[16] = '{0,0,0,0,3'd0, 5'd15,0,RU};
    tbl[17] = '{0,0,0,0,3'd0, 5'd15,0,RU};
    tbl[18] = '{0,0,0,0,3'd0, 5'd15,0,RU};
    tbl[19] = '{0,0,0,0,3'd0, 5'd14,1,RU};
    tbl[20] = '{0,0,0,0,3'd0, 5'd14,0,RU};
    tbl[21] = '{0,0,0,1,3'd5, 5'd15,0,PA};
    tbl[22] = '{0,1,0,0,3'd0, 5'd15,0,RU};
    tbl[23] = '{0,0,0,0,3'd0, 5'd15,0,RU};
    tbl[24] = '{0,0,0,0,3'd0, 5'd15,0,RU};
    tbl[25] = '{0,0,0,0,3'd0, 5'd15,0,RU};
    tbl[26] = '{0,0,0,0,3'd0, 5'd14,1,RU};
    tbl[27] = '{1,0,0,0,3'd0, 5'd10,0,ID};

    zera_n = 0;
    carrega = 0; inicia = 0; pausa = 0; jogada = 0; bonus = 0;
    #12;
    chk("reset", 5'd10, 1'b0, ID);
    zera_n = 1;
    @(posedge clock);
    #1;
    chk("post_reset", 5'd10, 1'b0, ID);

    for (int n = 0; n < 28; n++) begin
      cyc(tbl[n].c, tbl[n].i, tbl[n].p, tbl[n].j, tbl[n].b);
      chk($sformatf("vec%0d", n), tbl[n].q, tbl[n].pl, tbl[n].st);
    end

    // Full countdown to expiry, then commands other than carrega ignored.
    cyc(0, 1, 0, 0, 0);
    chk("exp_start", 5'd10, 1'b0, RU);
    run_to(10, 0, "exp_run");
    cyc(0, 0, 0, 1, 3'd4);
    chk("exp_jogada", 5'd0, 1'b0, EX);
    cyc(0, 1, 0, 0, 0);
    chk("exp_inicia", 5'd0, 1'b0, EX);
    cyc(0, 0, 1, 0, 0);
    chk("exp_pausa", 5'd0, 1'b0, EX);
    cyc(1, 0, 0, 0, 0);
    chk("exp_carrega", 5'd10, 1'b0, ID);

    // Move on the final tick beats expiry.
    cyc(0, 1, 0, 0, 0);
    chk("last_start", 5'd10, 1'b0, RU);
    run_to(10, 1, "last_run");
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 0, 0);
      chk("last_presc", 5'd1, 1'b0, RU);
    end
    cyc(0, 0, 0, 1, 3'd2);
    chk("last_jogada", 5'd3, 1'b0, PA);
    cyc(0, 1, 0, 0, 0);
    chk("last_resume", 5'd3, 1'b0, RU);
    run_to(3, 2, "last_cleared");

    // Pause keeps the prescaler residual.
    cyc(1, 0, 0, 0, 0);
    chk("p_carrega", 5'd10, 1'b0, ID);
    cyc(0, 1, 0, 0, 0);
    chk("p_start", 5'd10, 1'b0, RU);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("p_two", 5'd10, 1'b0, RU);
    cyc(0, 0, 1, 0, 0);
    chk("p_pause", 5'd10, 1'b0, PA);
    for (int k = 0; k < 20; k++) begin
      cyc(0, 0, 0, 0, 0);
      chk("p_hold", 5'd10, 1'b0, PA);
    end
    cyc(0, 1, 0, 0, 0);
    chk("p_resume", 5'd10, 1'b0, RU);
    cyc(0, 0, 0, 0, 0);
    chk("p_plus1", 5'd10, 1'b0, RU);
    cyc(0, 0, 0, 0, 0);
    chk("p_plus2", 5'd9, 1'b1, RU);

    // Asynchronous reset mid-cycle while running.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("r_start", 5'd10, 1'b0, RU);
    run_to(10, 6, "r_run");
    #3;
    zera_n = 0;
    #1;
    chk("r_async", 5'd10, 1'b0, ID);
    #2;
    zera_n = 1;
    @(posedge clock);
    #1;
    chk("r_after", 5'd10, 1'b0, ID);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/temporizador_regressivo.md
Name: temporizador_regressivo

Overview:
- Per-player countdown clock for the chess clock datapath.
- Counts remaining time down from a loaded value.
- Adds a bonus (Fischer increment) when the player completes a move.
- Flags time expiry.
- Complements the elapsed-time up-counter: consumes time where that one accumulates it. One instance per player, driven by the game-control FSM.

Parameters:
- M, 6000, saturation cap; Q never exceeds M-1.
- N, 13, width of Q; 2^N >= M.
- INICIAL, 3000, value loaded on reset and carrega; must be <= M-1.
- DIV, 50000, clock cycles per time unit (internal prescaler period); DIV >= 2.
- B, 4, width of the bonus input.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- zera_n  in  1  asynchronous active-low reset.
- carrega  in  1  synchronous reload: Q<=INICIAL, state IDLE.
- inicia  in  1  start/resume counting.
- pausa  in  1  stop counting and keep Q.
- jogada  in  1  move completed: add bonus, stop counting.
- bonus  in  B  time units added on jogada.
- Q  out  N  remaining time units (registered).
- pulso  out  1  one-cycle strobe on each decrement (registered).
- fim  out  1  high while in EXPIRED.
- estado  out  2  00 IDLE, 01 RUNNING, 10 PAUSED, 11 EXPIRED.

Behaviour:
- Reset (zera_n=0, asynchronous): Q=INICIAL, estado=IDLE, prescaler=0, pulso=0, fim=0.
- Internal prescaler 0..DIV-1 increments only in RUNNING.
  - At DIV-1 it wraps to 0 and a tick occurs that cycle.
  - Held (not cleared) in PAUSED/IDLE.
  - Cleared on carrega and jogada.
- Tick in RUNNING:
  - Q<=Q-1 and pulso=1 next cycle.
  - If Q==1, Q<=0 and estado<=EXPIRED in the same edge.
- Command priority per cycle: carrega > jogada > pausa > inicia > tick. Only the highest active event takes effect.
- IDLE:
  - inicia: RUNNING if Q>0, else EXPIRED.
  - pausa and jogada are ignored.
- RUNNING:
  - pausa: PAUSED.
  - jogada: Q<=min(Q+bonus, M-1), state PAUSED. The tick in that cycle is discarded, so a move on the final tick beats expiry.
  - inicia: no effect.
- PAUSED:
  - inicia: RUNNING if Q>0, else EXPIRED.
  - jogada: adds bonus (saturating) and stays PAUSED.
  - pausa: no effect.
- EXPIRED:
  - Q holds 0 and fim=1.
  - jogada, pausa and inicia are ignored; only carrega or zera_n leave this state.
- Arithmetic: bonus is zero-extended to N+1 bits before the add, then compared against M-1. No wrap on overflow; Q never underflows below 0.
- fim is decoded from the registered estado, so it rises on the same edge Q becomes 0.
- pulso is high for exactly one cycle per decrement. It is 0 on any cycle where a higher-priority command pre-empted the tick.
- Reset mid-count: the prescaler residual is lost and the full INICIAL is restored.

Test Plan:
Bench parameters: M=16, N=5, INICIAL=10, DIV=4, B=3.
1. Release zera_n and pulse inicia -> estado=01; a pulso every 4 cycles; Q goes 10,9,8,...
2. Run until Q=1, then one more tick -> Q=0, estado=11 and fim=1 on the same edge. Later jogada/inicia -> no change. carrega -> Q=10, estado=00, fim=0.
3. RUNNING with Q=14, jogada with bonus=5 -> Q=15 (saturated at M-1), estado=10, prescaler cleared.
4. Q=1 with the prescaler at DIV-1; assert jogada with bonus=2 in the tick cycle -> Q=3, estado=10, no pulso, fim stays 0.
5. Pausa after 2 prescaler cycles, wait 20 cycles, then inicia -> no decrement while paused; the next pulso arrives 2 cycles after resume.
6. Drop zera_n asynchronously mid-cycle during RUNNING with Q=6 -> Q=10, estado=00, pulso=0 immediately, with no clock edge needed.
